// File: rtl/srl_fifo.sv
// Small elastic FIFO built on a shift-register (SRL) store with a registered read port.
// The controller tracks occupancy and whether the SRL output register currently holds the oldest word.

module shift_register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ASB  = $clog2(DEPTH) - 1
) (
  input  logic             clock,
  input  logic             wren_i,
  input  logic [ASB:0]     addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] srl [DEPTH];

  // The read register samples the pre-shift contents every cycle.
  always_ff @(posedge clock) begin
    if (wren_i) begin
      srl[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
    data_o <= srl[addr_i];
  end

endmodule

module srl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ASB  = $clog2(DEPTH) - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [ASB+1:0]   level_o
);

  localparam int CW = ASB + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          fresh;
  logic          fresh_next;
  logic          push;
  logic          pop;
  logic [ASB:0]  addr;

  assign ready_o = (count != FULL);
  assign valid_o = fresh & (count != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign level_o = count;

  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);

    // Address wraps when the result is unused (count = 1 with a pop).
    addr = pop ? (count[ASB:0] - (ASB+1)'(2)) : (count[ASB:0] - (ASB+1)'(1));

    // A word that becomes oldest only through this cycle's shift is not yet in the read register.
    fresh_next = (count_next != '0) && (pop ? (count >= CW'(2)) : (count >= CW'(1)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      fresh <= 1'b0;
    end else begin
      count <= count_next;
      fresh <= fresh_next;
    end
  end

  shift_register #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_srl (
    .clock  (clock),
    .wren_i (push),
    .addr_i (addr),
    .data_i (data_i),
    .data_o (data_o)
  );

endmodule

// File: doc/srl_fifo.md
# srl_fifo

Synchronous FIFO controller that sequences one `shift_register` instance (WIDTH × DEPTH) as queue storage, with valid/ready handshakes on both sides. The controller owns the SRL write-enable and read address and tracks occupancy. Because the SRL read port is registered, it also tracks whether the presented word is current. It sits between AXI-side and DDR3-side pipeline stages wherever a small, LUT-efficient elastic buffer is needed.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: entries; a power of two, ≥ 2.
- `ASB`, localparam $clog2(DEPTH)-1: SRL address MSB.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `valid_i`  in  1: upstream word valid.
- `ready_o`  out  1: space available; push = valid_i & ready_o.
- `data_i`  in  WIDTH: upstream word.
- `valid_o`  out  1: `data_o` holds the oldest stored word.
- `ready_i`  in  1: downstream accepts; pop = valid_o & ready_i.
- `data_o`  out  WIDTH: oldest word, driven directly by the SRL registered output.
- `level_o`  out  ASB+2: stored word count, 0..DEPTH.

## Operation
- Internal state:
  - `count` (ASB+2 bits, equal to `level_o`).
  - `fresh` (1 bit): the SRL output register holds the entry at index count-1.
- SRL connections:
  - SRL `wren_i` = push.
  - SRL `data_i` = `data_i`.
  - SRL `addr_i` = pop ? count-2 : count-1, truncated to ASB+1 bits; the value is don't-care when the result is not used.
- Entry order: newest at srl[0], oldest at srl[count-1], before the shift.
- Flags:
  - `ready_o` = (count != DEPTH).
  - `valid_o` = fresh & (count != 0).
- Count update: count_next = count + push − pop, computed at full ASB+2 width. It never wraps.
- Fresh update: fresh_next = (count_next != 0) & (pop ? count ≥ 2 : count ≥ 1).
  - The SRL samples its pre-shift contents.
  - A word pushed into an empty queue, or a word that becomes oldest only through a same-cycle push, is not readable until one cycle later.
- Boundary cases:
  - Full (count = DEPTH): `ready_o` = 0, so no push occurs even if a pop happens in the same cycle.
  - Empty: `valid_o` = 0 and pop is impossible. `data_o` is don't-care.
  - Push & pop in the same cycle at count ≥ 2: count is unchanged and `valid_o` stays 1, giving full throughput.
  - Push & pop in the same cycle at count = 1: count stays 1 and `valid_o` drops for exactly one cycle (one bubble). This is the required behaviour, not a defect.
  - Push while not fresh and count ≥ 1: the read address stays at the oldest entry; `valid_o` rises the next cycle.
- Reset (asynchronous assert, release synchronous to `clock`):
  - count = 0 and fresh = 0, so `valid_o` = 0, `ready_o` = 1, `level_o` = 0.
  - SRL contents and `data_o` are not reset.
  - Reset asserted mid-operation discards all stored words immediately.

## Timing
- Push→valid latency: 2 cycles from an accepted push at cycle N into an empty queue.
  - Cycle N+1: `level_o` = 1, `valid_o` = 0.
  - Cycle N+2: `valid_o` = 1, `data_o` = the pushed word.
- Pop→next word: 1 cycle. After a pop at count ≥ 2, the next oldest word appears on `data_o` at N+1 with `valid_o` held high.
- `ready_o`, `valid_o` and `level_o` depend only on registered state (no combinational input→output paths). `data_o` is a registered SRL output.
- Throughput: one push and one pop per cycle when count ≥ 2.

## Test plan
- Reset state:
  - Assert `reset_n` = 0 mid-traffic at count = 5 → same-cycle `valid_o` = 0, `level_o` = 0, `ready_o` = 1.
  - After release, push 0xA1 → `data_o` = 0xA1 two cycles later.
- Fill and overflow guard:
  - Push 0x00..0x0F with `ready_i` = 0 → `ready_o` = 0 after the 16th push, `level_o` = 16.
  - A 17th `valid_i` is not accepted.
  - Then drain → 0x00..0x0F in order, one per cycle, with `valid_o` continuous.
- Empty latency: single push of 0x5C into empty → `valid_o` low at N+1, high at N+2 with `data_o` = 0x5C.
- Streaming at level ≥ 2:
  - Preload 2 words, then push and pop every cycle for 32 cycles → `level_o` stays 2, no `valid_o` gaps, output order matches input.
- Level-1 bubble: count = 1 with push & pop in the same cycle → `valid_o` = 0 for exactly one cycle, then the new word is valid; `level_o` stays 1.
- Random backpressure:
  - 10k cycles of random `valid_i`/`ready_i` checked against a scoreboard model → no loss, duplication or reorder.
  - `level_o` always equals pushes − pops.
